// File: rtl/i2c_pkg.sv
// Shared encodings for the byte-level I2C master: timing-stage command codes,
// controller state enum and default cycle counts at the 10 MHz FSM clock.
package i2c_pkg;

    localparam logic [4:0] CMD_IDLE      = 5'd0;
    localparam logic [4:0] CMD_START     = 5'd1;
    localparam logic [4:0] CMD_DATA      = 5'd2;
    localparam logic [4:0] CMD_CATCH_ACK = 5'd3;
    localparam logic [4:0] CMD_RESTART   = 5'd4;
    localparam logic [4:0] CMD_STOP      = 5'd5;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_TX        = 4'd2,
        ST_ACK_WAIT  = 4'd3,
        ST_RX        = 4'd4,
        ST_ACK_SEND  = 4'd5,
        ST_STOP_PREP = 4'd6,
        ST_STOP_SU   = 4'd7,
        ST_BUF       = 4'd8
    } fsm_state_t;

    localparam int FSM_CLK_HZ = 10_000_000;
    localparam int SU_STO_CYC = 20;
    localparam int BUF_CYC    = 24;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_shift_reg.sv
// 8-bit MSB-first shift register with a 3-bit bit counter; byte_end flags the
// last bit of the byte so the 8th count wraps the counter back to 0.
module i2c_shift_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift_en,
    input  logic       shift_bit,
    input  logic       cnt_en,
    output logic [7:0] data,
    output logic       byte_end
);

    logic [7:0] data_r;
    logic [2:0] bit_cnt_r;

    // Load takes priority; shifting and counting are independent so RX can
    // sample and count on different strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else if (load) begin
            data_r    <= load_data;
            bit_cnt_r <= 3'd0;
        end else begin
            if (shift_en) begin
                data_r <= {data_r[6:0], shift_bit};
            end
            if (cnt_en) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    assign data     = data_r;
    assign byte_end = (bit_cnt_r == 3'd7);

endmodule

// File: rtl/i2c_master_byte_fsm.sv
// Byte-level I2C master: sequences START, address, data bytes, ACK handling and
// STOP against the strobes of the downstream SCL timing stage.
module i2c_master_byte_fsm
    import i2c_pkg::*;
#(
    parameter int P_SU_STO_CYC = SU_STO_CYC,
    parameter int P_BUF_CYC    = BUF_CYC
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [6:0] i_addr,
    input  logic       i_rw,
    input  logic [3:0] i_len,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [4:0] o_cmd_state,
    input  logic       i_t_HD_STA_done,
    input  logic       i_t_HD_DAT_done,
    input  logic       i_t_Catch_ACK_done,
    input  logic       i_t_HIGH_done,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    output logic       o_underrun
);

    fsm_state_t state_r;
    logic [4:0] cmd_r;
    logic       sda_oe_r;
    logic       busy_r;
    logic       done_r;
    logic       nack_r;
    logic       underrun_r;
    logic       wr_ready_r;
    logic       rd_valid_r;
    logic [7:0] rd_data_r;
    logic       rw_r;
    logic [3:0] rem_r;
    logic       ack_r;
    logic [5:0] tcnt_r;

    logic       sr_load_s;
    logic [7:0] sr_load_data_s;
    logic       sr_shift_s;
    logic       sr_shift_bit_s;
    logic       sr_cnt_s;
    logic [7:0] sr_data_s;
    logic       sr_byte_end_s;
    logic       ack_bit_s;
    logic       wr_load_s;
    logic [7:0] rx_byte_s;

    // A sample strobe coincident with HIGH_done must be seen before the byte closes.
    assign ack_bit_s = i_t_Catch_ACK_done ? i_sda : ack_r;
    assign rx_byte_s = i_t_Catch_ACK_done ? {sr_data_s[6:0], i_sda} : sr_data_s;
    assign wr_load_s = (state_r == ST_ACK_WAIT) && i_t_HIGH_done && !ack_bit_s
                       && (rem_r != 4'd0) && !rw_r && i_wr_valid;

    // Shift-register control decoded from the current state and strobes.
    always_comb begin
        sr_load_s      = 1'b0;
        sr_load_data_s = i_wr_data;
        sr_shift_s     = 1'b0;
        sr_shift_bit_s = 1'b0;
        sr_cnt_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    sr_load_s      = 1'b1;
                    sr_load_data_s = addr_byte(i_addr, i_rw);
                end else begin
                    sr_load_s      = 1'b0;
                end
            end
            ST_TX: begin
                sr_shift_s = i_t_HIGH_done;
                sr_cnt_s   = i_t_HIGH_done;
            end
            ST_ACK_WAIT: begin
                sr_load_s = wr_load_s;
            end
            ST_RX: begin
                sr_shift_s     = i_t_Catch_ACK_done;
                sr_shift_bit_s = i_sda;
                sr_cnt_s       = i_t_HIGH_done;
            end
            default: begin
                sr_load_s = 1'b0;
            end
        endcase
    end

    i2c_shift_reg u_shift (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (sr_load_s),
        .load_data (sr_load_data_s),
        .shift_en  (sr_shift_s),
        .shift_bit (sr_shift_bit_s),
        .cnt_en    (sr_cnt_s),
        .data      (sr_data_s),
        .byte_end  (sr_byte_end_s)
    );

    // Transaction sequencer with all user-side and bus outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            cmd_r      <= CMD_IDLE;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            nack_r     <= 1'b0;
            underrun_r <= 1'b0;
            wr_ready_r <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 8'h00;
            rw_r       <= 1'b0;
            rem_r      <= 4'd0;
            ack_r      <= 1'b0;
            tcnt_r     <= 6'd0;
        end else begin
            done_r     <= 1'b0;
            wr_ready_r <= 1'b0;
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        rw_r       <= i_rw;
                        rem_r      <= i_len;
                        nack_r     <= 1'b0;
                        underrun_r <= 1'b0;
                        busy_r     <= 1'b1;
                        sda_oe_r   <= 1'b1;
                        cmd_r      <= CMD_START;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_t_HD_STA_done) begin
                        cmd_r   <= CMD_DATA;
                        state_r <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (i_t_HD_DAT_done) begin
                        sda_oe_r <= ~sr_data_s[7];
                    end
                    if (i_t_HIGH_done && sr_byte_end_s) begin
                        cmd_r   <= CMD_CATCH_ACK;
                        state_r <= ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (i_t_HD_DAT_done) begin
                        sda_oe_r <= 1'b0;
                    end
                    if (i_t_Catch_ACK_done) begin
                        ack_r <= i_sda;
                    end
                    if (i_t_HIGH_done) begin
                        if (ack_bit_s) begin
                            nack_r  <= 1'b1;
                            state_r <= ST_STOP_PREP;
                        end else if (rem_r == 4'd0) begin
                            state_r <= ST_STOP_PREP;
                        end else if (rw_r) begin
                            cmd_r   <= CMD_DATA;
                            state_r <= ST_RX;
                        end else if (wr_load_s) begin
                            wr_ready_r <= 1'b1;
                            rem_r      <= rem_r - 4'd1;
                            cmd_r      <= CMD_DATA;
                            state_r    <= ST_TX;
                        end else begin
                            underrun_r <= 1'b1;
                            state_r    <= ST_STOP_PREP;
                        end
                    end
                end
                ST_RX: begin
                    if (i_t_HD_DAT_done) begin
                        sda_oe_r <= 1'b0;
                    end
                    if (i_t_HIGH_done && sr_byte_end_s) begin
                        rd_data_r  <= rx_byte_s;
                        rd_valid_r <= 1'b1;
                        rem_r      <= rem_r - 4'd1;
                        cmd_r      <= CMD_CATCH_ACK;
                        state_r    <= ST_ACK_SEND;
                    end
                end
                ST_ACK_SEND: begin
                    if (i_t_HD_DAT_done) begin
                        sda_oe_r <= (rem_r != 4'd0);
                    end
                    if (i_t_HIGH_done) begin
                        if (rem_r != 4'd0) begin
                            cmd_r   <= CMD_DATA;
                            state_r <= ST_RX;
                        end else begin
                            state_r <= ST_STOP_PREP;
                        end
                    end
                end
                ST_STOP_PREP: begin
                    // tcnt_r marks that SDA is already low; STOP follows one cycle later.
                    if (tcnt_r != 6'd0) begin
                        tcnt_r  <= 6'd0;
                        cmd_r   <= CMD_STOP;
                        state_r <= ST_STOP_SU;
                    end else if (i_t_HD_DAT_done) begin
                        sda_oe_r <= 1'b1;
                        tcnt_r   <= 6'd1;
                    end
                end
                ST_STOP_SU: begin
                    if (tcnt_r == 6'(P_SU_STO_CYC - 1)) begin
                        sda_oe_r <= 1'b0;
                        tcnt_r   <= 6'd0;
                        state_r  <= ST_BUF;
                    end else begin
                        tcnt_r <= tcnt_r + 6'd1;
                    end
                end
                ST_BUF: begin
                    if (tcnt_r == 6'(P_BUF_CYC - 1)) begin
                        tcnt_r  <= 6'd0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        cmd_r   <= CMD_IDLE;
                        state_r <= ST_IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + 6'd1;
                    end
                end
                default: begin
                    sda_oe_r <= 1'b0;
                    busy_r   <= 1'b0;
                    tcnt_r   <= 6'd0;
                    cmd_r    <= CMD_IDLE;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wr_ready  = wr_ready_r;
    assign o_rd_data   = rd_data_r;
    assign o_rd_valid  = rd_valid_r;
    assign o_sda_oe    = sda_oe_r;
    assign o_cmd_state = cmd_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_nack      = nack_r;
    assign o_underrun  = underrun_r;

endmodule

// File: tb/tb_i2c_master_byte_fsm.sv
// Bench for i2c_master_byte_fsm: a randomized timing-stage/slave model drives the
// strobes and SDA, and a transaction-level model predicts bus bits and handshakes.
module tb_i2c_master_byte_fsm;

    localparam int SU  = 20;
    localparam int BUF = 24;
    localparam int NONE = 99;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic [6:0] i_addr;
    logic       i_rw;
    logic [3:0] i_len;
    logic [7:0] i_wr_data;
    logic       i_wr_valid;
    logic       o_wr_ready;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       i_sda;
    logic       o_sda_oe;
    logic [4:0] o_cmd_state;
    logic       i_t_HD_STA_done, i_t_HD_DAT_done, i_t_Catch_ACK_done, i_t_HIGH_done;
    logic       o_busy, o_done, o_nack, o_underrun;
    logic       slave_pull;

    i2c_master_byte_fsm #(.P_SU_STO_CYC(SU), .P_BUF_CYC(BUF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_addr(i_addr),
        .i_rw(i_rw), .i_len(i_len), .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid),
        .o_wr_ready(o_wr_ready), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .i_sda(i_sda), .o_sda_oe(o_sda_oe), .o_cmd_state(o_cmd_state),
        .i_t_HD_STA_done(i_t_HD_STA_done), .i_t_HD_DAT_done(i_t_HD_DAT_done),
        .i_t_Catch_ACK_done(i_t_Catch_ACK_done), .i_t_HIGH_done(i_t_HIGH_done),
        .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack), .o_underrun(o_underrun)
    );

    always #50 i_clk = ~i_clk;

    // Open-drain wire: low if either side pulls.
    assign i_sda = ~(o_sda_oe | slave_pull);

    int total = 0;
    int bad = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction configuration
    int         t_addr, t_rw, t_len, nack_byte, und_at;
    logic [7:0] wdata [16];
    logic [7:0] rdata [16];

    // Observations
    int         slot, wr_idx, wr_cnt, done_cnt, stop_cyc, stop_low;
    logic       done_seen, busy_at_done;
    logic [4:0] last_cmd;
    logic [4:0] got_cmd[$];
    logic [7:0] got_rd[$];
    logic       got_bits[$];

    // Expectations
    logic [4:0] exp_cmd[$];
    logic [7:0] exp_rd[$];
    logic       exp_bits[$];
    int         exp_wr;
    logic       exp_nack, exp_und;

    function automatic logic slave_drive(input int s);
        int b = s / 9;
        int k = s % 9;
        if (k == 8) begin
            if (b == 0 || t_rw == 0) return (nack_byte != b);
            return 1'b0;
        end
        if (t_rw != 0 && b >= 1 && b <= t_len && nack_byte != 0) return ~rdata[b-1][7-k];
        return 1'b0;
    endfunction

    task automatic feed_wr();
        i_wr_valid = (wr_idx < und_at) && (wr_idx < t_len);
        i_wr_data  = (wr_idx < 16) ? wdata[wr_idx] : 8'h00;
    endtask

    task automatic tick();
        @(negedge i_clk);
        if (o_cmd_state != last_cmd) begin
            got_cmd.push_back(o_cmd_state);
            last_cmd = o_cmd_state;
        end
        if (o_wr_ready) begin
            wr_cnt++;
            wr_idx++;
        end
        if (o_rd_valid) got_rd.push_back(o_rd_data);
        if (o_done) begin
            done_cnt++;
            done_seen = 1'b1;
            busy_at_done = o_busy;
        end
        if (o_cmd_state == 5'd5) begin
            stop_cyc++;
            if (o_sda_oe) stop_low++;
        end
        feed_wr();
    endtask

    task automatic push_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        exp_bits.push_back(ack);
        exp_cmd.push_back(5'd2);
        exp_cmd.push_back(5'd3);
    endtask

    task automatic build_expect();
        exp_cmd.delete(); exp_rd.delete(); exp_bits.delete();
        exp_wr = 0; exp_nack = 1'b0; exp_und = 1'b0;
        exp_cmd.push_back(5'd1);
        push_byte({t_addr[6:0], t_rw[0]}, (nack_byte == 0));
        if (nack_byte == 0) begin
            exp_nack = 1'b1;
        end else if (t_rw != 0) begin
            for (int i = 0; i < t_len; i++) begin
                push_byte(rdata[i], (i == t_len - 1));
                exp_rd.push_back(rdata[i]);
            end
        end else begin
            for (int i = 0; i < t_len; i++) begin
                if (i >= und_at) begin
                    exp_und = 1'b1;
                    break;
                end
                exp_wr++;
                push_byte(wdata[i], (nack_byte == i + 1));
                if (nack_byte == i + 1) begin
                    exp_nack = 1'b1;
                    break;
                end
            end
        end
        exp_cmd.push_back(5'd5);
        exp_cmd.push_back(5'd0);
    endtask

    task automatic do_slot();
        bit both;
        slave_pull = slave_drive(slot);
        i_t_HD_DAT_done = 1'b1;
        tick();
        i_t_HD_DAT_done = 1'b0;
        repeat ($urandom_range(2, 4)) tick();
        if (o_cmd_state != 5'd2 && o_cmd_state != 5'd3) return;
        got_bits.push_back(i_sda);
        both = ($urandom_range(0, 3) == 0);
        i_t_Catch_ACK_done = 1'b1;
        i_t_HIGH_done = both;
        tick();
        i_t_Catch_ACK_done = 1'b0;
        i_t_HIGH_done = 1'b0;
        if (!both) begin
            repeat ($urandom_range(0, 2)) tick();
            i_t_HIGH_done = 1'b1;
            tick();
            i_t_HIGH_done = 1'b0;
        end
        slot++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_cmd"}, o_cmd_state, 5'd0);
        check_value({tag, "_oe"}, o_sda_oe, 1'b0);
        check_value({tag, "_flags"}, {o_busy, o_done, o_nack, o_underrun, o_wr_ready, o_rd_valid}, 6'd0);
        check_value({tag, "_rd_data"}, o_rd_data, 8'h00);
    endtask

    task automatic run_txn(input int abort_slot, input bit ghost);
        bit aborted = 1'b0;
        bit ghost_done = 1'b0;
        logic [8:0] g, e;
        got_cmd.delete(); got_rd.delete(); got_bits.delete();
        wr_idx = 0; wr_cnt = 0; done_cnt = 0; stop_cyc = 0; stop_low = 0;
        done_seen = 1'b0; busy_at_done = 1'b1; last_cmd = o_cmd_state; slot = 0;
        slave_pull = 1'b0;
        build_expect();
        feed_wr();
        i_addr = t_addr[6:0]; i_rw = t_rw[0]; i_len = t_len[3:0];
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            tick();
            if (done_seen) break;
            if (abort_slot >= 0 && slot == abort_slot) begin
                aborted = 1'b1;
                break;
            end
            if (ghost && !ghost_done && slot == 2) begin
                ghost_done = 1'b1;
                i_addr = ~t_addr[6:0]; i_rw = ~t_rw[0]; i_len = ~t_len[3:0];
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
                continue;
            end
            case (o_cmd_state)
                5'd1: begin
                    i_t_HD_STA_done = 1'b1;
                    tick();
                    i_t_HD_STA_done = 1'b0;
                end
                5'd2, 5'd3: do_slot();
                default: ;
            endcase
        end
        if (aborted) begin
            i_rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            slave_pull = 1'b0;
            repeat (2) tick();
            i_rst_n = 1'b1;
            return;
        end
        check_value("done_seen", done_seen, 1'b1);
        repeat (3) tick();
        check_value("done_pulses", done_cnt, 1);
        check_value("busy_at_done", busy_at_done, 1'b0);
        check_value("nack", o_nack, exp_nack);
        check_value("underrun", o_underrun, exp_und);
        check_value("wr_ready_cnt", wr_cnt, exp_wr);
        check_value("rd_cnt", got_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            check_value("rd_data", got_rd[i], exp_rd[i]);
        check_value("cmd_len", got_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
            check_value("cmd_seq", got_cmd[i], exp_cmd[i]);
        check_value("bus_bits", got_bits.size(), exp_bits.size());
        for (int i = 0; i + 8 < exp_bits.size() && i + 8 < got_bits.size(); i += 9) begin
            for (int j = 0; j < 9; j++) begin
                g[8-j] = got_bits[i+j];
                e[8-j] = exp_bits[i+j];
            end
            check_value("bus_byte_ack", g, e);
        end
        check_value("stop_cycles", stop_cyc, SU + BUF);
        check_value("stop_sda_low", stop_low, SU);
        check_value("idle_oe_busy", {o_sda_oe, o_busy}, 2'b00);
    endtask

    task automatic set_txn(input int a, input int rw, input int len, input int nb, input int ua);
        t_addr = a; t_rw = rw; t_len = len; nack_byte = nb; und_at = ua;
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_addr = 7'd0; i_rw = 1'b0; i_len = 4'd0;
        i_wr_data = 8'h00; i_wr_valid = 1'b0; slave_pull = 1'b0;
        i_t_HD_STA_done = 1'b0; i_t_HD_DAT_done = 1'b0;
        i_t_Catch_ACK_done = 1'b0; i_t_HIGH_done = 1'b0;
        t_len = 0; und_at = NONE; wr_idx = 0;
        for (int i = 0; i < 16; i++) begin
            wdata[i] = 8'($urandom);
            rdata[i] = 8'($urandom);
        end
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Write one byte, slave ACKs everything
        wdata[0] = 8'hA5;
        set_txn(7'h50, 0, 1, NONE, NONE); run_txn(-1, 1'b0);
        // Address NACK
        set_txn(7'h50, 0, 1, 0, NONE); run_txn(-1, 1'b0);
        // Read two bytes
        rdata[0] = 8'h3C; rdata[1] = 8'hC3;
        set_txn(7'h50, 1, 2, NONE, NONE); run_txn(-1, 1'b0);
        // Second write byte not available
        set_txn(7'h50, 0, 2, NONE, 1); run_txn(-1, 1'b0);
        // Address-only probe with an ignored second start
        set_txn(7'h3C, 0, 0, NONE, NONE); run_txn(-1, 1'b1);
        // Reset in the middle of the address byte, then a clean transaction
        set_txn(7'h50, 0, 1, NONE, NONE); run_txn(4, 1'b0);
        set_txn(7'h21, 0, 2, NONE, NONE); run_txn(-1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) begin
                wdata[i] = 8'($urandom);
                rdata[i] = 8'($urandom);
            end
            t_len = $urandom_range(0, (r % 5 == 0) ? 15 : 5);
            set_txn($urandom_range(0, 127), $urandom_range(0, 1), t_len,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, t_len) : NONE,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, t_len) : NONE);
            run_txn(-1, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
